mul2_engine: RTL

- Hardware sequential engine for program 2: 8-bit two's-complement OpA × OpB → 16-bit two's-complement product.
- Shares the single-port byte data memory with the core and obeys the same start/done contract as the top-level DUT.
- Reads OpA from dm[0] and OpB from dm[1]; writes the product little-endian: low byte to dm[2], high byte to dm[3].
- Used as a drop-in accelerator and as the golden RTL model for program-2 regression.

---
 rtl/mul2_pkg.sv | 17 +
 rtl/mul2_core.sv | 50 +++++
 rtl/mul2_engine.sv | 118 +++++++++++
 3 files changed

// File: rtl/mul2_pkg.sv
// Shared types and constants for the program-2 signed multiply engine.
package mul2_pkg;

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, MUL, WR_LO, WR_HI, DONE} state_t;

   localparam int unsigned MUL_ITERS         = 8;
   localparam int unsigned DEF_OPA_ADDR      = 0;
   localparam int unsigned DEF_OPB_ADDR      = 1;
   localparam int unsigned DEF_PROD_LO_ADDR  = 2;
   localparam int unsigned DEF_PROD_HI_ADDR  = 3;

   // Unsigned magnitude of a two's-complement byte; -128 maps to 8'h80.
   function automatic logic [7:0] mag8(input logic [7:0] x);
      return x[7] ? (~x + 8'd1) : x;
   endfunction

endpackage

// File: rtl/mul2_core.sv
// Unsigned 8x8 iterative shift-add multiplier, one partial product per cycle.
module mul2_core
   import mul2_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [7:0]  mcand,
   input  logic [7:0]  mlr,
   output logic        busy,
   output logic [15:0] prod
);

   logic [7:0] mcand_q;
   logic [7:0] acc_q;
   logic [7:0] mlr_q;
   logic [3:0] cnt_q;
   logic       busy_q;
   logic [8:0] sum;

   always_comb begin
      sum = {1'b0, acc_q} + (mlr_q[0] ? {1'b0, mcand_q} : 9'd0);
   end

   // {carry,acc} shifts right as a unit, its low bit entering the multiplier.
   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q <= '0;
         acc_q   <= '0;
         mlr_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else if (load) begin
         mcand_q <= mcand;
         mlr_q   <= mlr;
         acc_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else if (busy_q) begin
         acc_q <= sum[8:1];
         mlr_q <= {sum[0], mlr_q[7:1]};
         if (cnt_q == 4'(MUL_ITERS - 1)) busy_q <= 1'b0;
         else                            cnt_q  <= cnt_q + 4'd1;
      end
   end

   assign busy = busy_q;
   assign prod = {acc_q, mlr_q};

endmodule

// File: rtl/mul2_engine.sv
// Program-2 accelerator: reads two signed bytes from data memory, writes the
// signed 16-bit product back little-endian, with a start-falling-edge/done handshake.
module mul2_engine
   import mul2_pkg::*;
#(
   parameter int unsigned          ADDR_W       = 8,
   parameter logic [ADDR_W-1:0]    OPA_ADDR     = ADDR_W'(DEF_OPA_ADDR),
   parameter logic [ADDR_W-1:0]    OPB_ADDR     = ADDR_W'(DEF_OPB_ADDR),
   parameter logic [ADDR_W-1:0]    PROD_LO_ADDR = ADDR_W'(DEF_PROD_LO_ADDR),
   parameter logic [ADDR_W-1:0]    PROD_HI_ADDR = ADDR_W'(DEF_PROD_HI_ADDR)
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wr_data,
   input  logic [7:0]        mem_rd_data
);

   state_t      state_q, state_d;
   logic        start_q;
   logic [7:0]  a_q, b_q;
   logic [3:0]  cnt_q;
   logic        done_q;
   logic        core_load;
   logic        core_busy;
   logic [15:0] core_prod;
   logic        neg;
   logic [15:0] p;

   mul2_core u_core (
      .clk   (clk),
      .reset (reset),
      .load  (core_load),
      .mcand (mag8(a_q)),
      .mlr   (mag8(mem_rd_data)),
      .busy  (core_busy),
      .prod  (core_prod)
   );

   assign neg = a_q[7] ^ b_q[7];
   assign p   = neg ? (~core_prod + 16'd1) : core_prod;

   // start history runs through reset so a falling edge right after release launches.
   always_ff @(posedge clk) begin
      start_q <= start;
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      mem_addr    = OPA_ADDR;
      mem_wr_en   = 1'b0;
      mem_wr_data = '0;
      core_load   = 1'b0;
      case (state_q)
         IDLE:  if (start_q && !start) state_d = RD_A;
         RD_A:  state_d = RD_B;
         RD_B: begin
            mem_addr  = OPB_ADDR;
            core_load = 1'b1;
            state_d   = MUL;
         end
         MUL:   if (core_busy && cnt_q == 4'(MUL_ITERS - 1)) state_d = WR_LO;
         WR_LO: begin
            mem_addr    = PROD_LO_ADDR;
            mem_wr_data = p[7:0];
            mem_wr_en   = 1'b1;
            state_d     = WR_HI;
         end
         WR_HI: begin
            mem_addr    = PROD_HI_ADDR;
            mem_wr_data = p[15:8];
            mem_wr_en   = 1'b1;
            state_d     = DONE;
         end
         DONE:  if (start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Reset masks the memory interface immediately so no write lands on the reset edge.
      if (reset) begin
         mem_addr    = OPA_ADDR;
         mem_wr_en   = 1'b0;
         mem_wr_data = '0;
         core_load   = 1'b0;
         state_d     = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         case (state_q)
            RD_A: a_q <= mem_rd_data;
            RD_B: begin
               b_q   <= mem_rd_data;
               cnt_q <= '0;
            end
            MUL:  cnt_q <= cnt_q + 4'd1;
            default: ;
         endcase
         done_q <= (state_d == DONE);
      end
   end

   assign done = done_q;

endmodule
